// File: rtl/ddr_pkg.sv
// Shared definitions for the block-request to MIG app_* bridge.
// Command codes, state encoding and block width.
package ddr_pkg;

    localparam int BLOCK_W = 256;

    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR_DATA = 3'd1;
    localparam logic [2:0] ST_WR_CMD  = 3'd2;
    localparam logic [2:0] ST_RD_CMD  = 3'd3;
    localparam logic [2:0] ST_RD_WAIT = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_WR_DATA = ST_WR_DATA,
        S_WR_CMD  = ST_WR_CMD,
        S_RD_CMD  = ST_RD_CMD,
        S_RD_WAIT = ST_RD_WAIT,
        S_DONE    = ST_DONE
    } state_t;

endpackage

// File: rtl/ddr_req_responder.sv
// Splits each 256-bit block request into two 128-bit MIG
// app_* transactions; read beats are staged, then published whole.
module ddr_req_responder
    import ddr_pkg::*;
#(
    parameter int APP_ADDR_W = 27,
    parameter int APP_DATA_W = 128,
    parameter int RAM_ADDR_W = 30
) (
    input  logic                    ui_clk,
    input  logic                    rst,
    input  logic                    ram_en,
    input  logic                    ram_write,
    input  logic [RAM_ADDR_W-1:0]   ram_addr,
    input  logic [2*APP_DATA_W-1:0] data_to_ram,
    output logic                    ram_rdy,
    output logic [2*APP_DATA_W-1:0] block_out,
    input  logic                    init_calib_complete,
    output logic [APP_ADDR_W-1:0]   app_addr,
    output logic [2:0]              app_cmd,
    output logic                    app_en,
    input  logic                    app_rdy,
    output logic [APP_DATA_W-1:0]   app_wdf_data,
    output logic                    app_wdf_wren,
    output logic                    app_wdf_end,
    output logic [APP_DATA_W/8-1:0] app_wdf_mask,
    input  logic                    app_wdf_rdy,
    input  logic [APP_DATA_W-1:0]   app_rd_data,
    input  logic                    app_rd_data_valid
);

    localparam int BW   = 2 * APP_DATA_W;
    localparam int BA_W = APP_ADDR_W - 5;

    state_t            state;
    logic              beat;
    logic [1:0]        rd_cnt;
    logic [BA_W-1:0]   addr_q;
    logic [BW-1:0]     wdata_q;
    logic [BW-1:0]     stage;
    logic              unused_ok;

    // Block index bits beyond the DDR size are dropped.
    assign unused_ok    = ^ram_addr[RAM_ADDR_W-1:BA_W];
    assign app_wdf_end  = app_wdf_wren;
    assign app_wdf_mask = '0;

    function automatic logic [APP_ADDR_W-1:0] mk_addr(
        input logic [BA_W-1:0] a,
        input logic            h
    );
        return {a, h, 4'b0000};
    endfunction

    always_ff @(posedge ui_clk) begin
        if (!rst) begin
            state        <= S_IDLE;
            beat         <= 1'b0;
            rd_cnt       <= 2'd0;
            addr_q       <= '0;
            wdata_q      <= '0;
            stage        <= '0;
            block_out    <= '0;
            ram_rdy      <= 1'b0;
            app_en       <= 1'b0;
            app_addr     <= '0;
            app_cmd      <= 3'b000;
            app_wdf_wren <= 1'b0;
            app_wdf_data <= '0;
        end else begin
            ram_rdy <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (init_calib_complete && ram_en) begin
                        addr_q  <= ram_addr[BA_W-1:0];
                        wdata_q <= data_to_ram;
                        beat    <= 1'b0;
                        rd_cnt  <= 2'd0;
                        if (ram_write) begin
                            state        <= S_WR_DATA;
                            app_wdf_wren <= 1'b1;
                            app_wdf_data <= data_to_ram[APP_DATA_W-1:0];
                        end else begin
                            state    <= S_RD_CMD;
                            app_en   <= 1'b1;
                            app_cmd  <= CMD_RD;
                            app_addr <= mk_addr(ram_addr[BA_W-1:0], 1'b0);
                        end
                    end
                end
                S_WR_DATA: begin
                    if (app_wdf_rdy) begin
                        app_wdf_wren <= 1'b0;
                        app_en       <= 1'b1;
                        app_cmd      <= CMD_WR;
                        app_addr     <= mk_addr(addr_q, beat);
                        state        <= S_WR_CMD;
                    end
                end
                S_WR_CMD: begin
                    if (app_rdy) begin
                        app_en <= 1'b0;
                        if (!beat) begin
                            beat         <= 1'b1;
                            app_wdf_wren <= 1'b1;
                            app_wdf_data <= wdata_q[BW-1:APP_DATA_W];
                            state        <= S_WR_DATA;
                        end else begin
                            ram_rdy <= 1'b1;
                            state   <= S_DONE;
                        end
                    end
                end
                S_RD_CMD: begin
                    if (app_rdy) begin
                        if (!beat) begin
                            beat     <= 1'b1;
                            app_addr <= mk_addr(addr_q, 1'b1);
                        end else begin
                            app_en <= 1'b0;
                            state  <= S_RD_WAIT;
                        end
                    end
                end
                S_RD_WAIT: begin
                    if (rd_cnt == 2'd2) begin
                        ram_rdy   <= 1'b1;
                        block_out <= stage;
                        state     <= S_DONE;
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            // Beats may land while the second read command is pending.
            if ((state == S_RD_CMD || state == S_RD_WAIT) &&
                app_rd_data_valid && rd_cnt != 2'd2) begin
                if (rd_cnt[0])
                    stage[BW-1:APP_DATA_W] <= app_rd_data;
                else
                    stage[APP_DATA_W-1:0] <= app_rd_data;
                rd_cnt <= rd_cnt + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_ddr_req_responder.sv
// Bench for ddr_req_responder: DDR/MIG model, request scoreboard,
// per-cycle compare process and directed literal checks.
module tb_ddr_req_responder;
    import ddr_pkg::*;

    logic         ui_clk = 1'b0;
    logic         rst;
    logic         ram_en, ram_write;
    logic [29:0]  ram_addr;
    logic [255:0] data_to_ram;
    logic         ram_rdy;
    logic [255:0] block_out;
    logic         init_calib_complete;
    logic [26:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en, app_rdy;
    logic [127:0] app_wdf_data;
    logic         app_wdf_wren, app_wdf_end;
    logic [15:0]  app_wdf_mask;
    logic         app_wdf_rdy;
    logic [127:0] app_rd_data;
    logic         app_rd_data_valid;

    always #5 ui_clk = ~ui_clk;

    ddr_req_responder dut (
        .ui_clk(ui_clk), .rst(rst),
        .ram_en(ram_en), .ram_write(ram_write),
        .ram_addr(ram_addr), .data_to_ram(data_to_ram),
        .ram_rdy(ram_rdy), .block_out(block_out),
        .init_calib_complete(init_calib_complete),
        .app_addr(app_addr), .app_cmd(app_cmd),
        .app_en(app_en), .app_rdy(app_rdy),
        .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren),
        .app_wdf_end(app_wdf_end), .app_wdf_mask(app_wdf_mask),
        .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data),
        .app_rd_data_valid(app_rd_data_valid)
    );

    typedef struct { logic [26:0] a; logic [2:0] c; } cmd_t;
    typedef struct { logic w; logic [255:0] blk; } req_t;
    typedef struct { int due; logic [127:0] d; } rd_t;

    int errors = 0;
    int checks = 0;

    cmd_t         exp_cmd[$];
    cmd_t         cmd_log[$];
    logic [127:0] exp_wdf[$];
    logic [127:0] wdf_log[$];
    logic [127:0] wdf_q[$];
    req_t         req_q[$];
    rd_t          rdq[$];
    logic [127:0] mig_mem[int];
    logic [255:0] ref_mem[int];
    logic [255:0] exp_blk = '0;
    bit           bp = 1'b0;
    int           rd_lat = 3;
    int           cyc = 0;

    task automatic chk(input string name, input logic [255:0] act,
                       input logic [255:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic logic [26:0] ea(input logic [29:0] a, input logic h);
        return {a[21:0], h, 4'b0000};
    endfunction

    // Queue what a request must produce on the MIG side and at completion.
    task automatic start_req(input logic w, input logic [29:0] a,
                             input logic [255:0] d);
        int k;
        req_t r;
        k = int'(a[21:0]);
        if (w) begin
            exp_wdf.push_back(d[127:0]);
            exp_wdf.push_back(d[255:128]);
            ref_mem[k] = d;
        end
        exp_cmd.push_back('{ea(a, 1'b0), w ? CMD_WR : CMD_RD});
        exp_cmd.push_back('{ea(a, 1'b1), w ? CMD_WR : CMD_RD});
        r.w = w;
        r.blk = (!w && ref_mem.exists(k)) ? ref_mem[k] : '0;
        req_q.push_back(r);
        ram_write = w;
        ram_addr = a;
        data_to_ram = d;
        ram_en = 1'b1;
    endtask

    task automatic wait_rdy(output int n, output logic [255:0] pre_blk);
        n = 0;
        pre_blk = block_out;
        while (n < 2000) begin
            pre_blk = block_out;
            @(negedge ui_clk);
            n++;
            if (ram_rdy) break;
        end
        chk("ram_rdy_seen", ram_rdy, 1);
    endtask

    // MIG/DDR model plus the per-cycle compare process.
    initial begin
        rd_t          r;
        req_t         q;
        cmd_t         c;
        int           k;
        logic         en_stall, wd_stall;
        cmd_t         prev_c;
        logic [127:0] prev_d;
        en_stall = 1'b0;
        wd_stall = 1'b0;
        prev_c = '{27'd0, 3'd0};
        prev_d = '0;
        app_rdy = 1'b1;
        app_wdf_rdy = 1'b1;
        app_rd_data_valid = 1'b0;
        app_rd_data = '0;
        forever begin
            @(negedge ui_clk);
            #1;
            cyc++;
            app_rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            app_wdf_rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rdq.size() > 0 && rdq[0].due <= cyc) begin
                r = rdq.pop_front();
                app_rd_data_valid = 1'b1;
                app_rd_data = r.d;
            end else begin
                app_rd_data_valid = 1'b0;
                app_rd_data = '0;
            end
            chk("wdf_end", app_wdf_end, app_wdf_wren);
            chk("wdf_mask", app_wdf_mask, 0);
            if (rst) begin
                if (en_stall)
                    chk("app_en_held", {app_en, app_addr, app_cmd},
                        {1'b1, prev_c.a, prev_c.c});
                if (wd_stall)
                    chk("wren_held", {app_wdf_wren, app_wdf_data},
                        {1'b1, prev_d});
                if (app_wdf_wren && app_wdf_rdy) begin
                    wdf_log.push_back(app_wdf_data);
                    wdf_q.push_back(app_wdf_data);
                    chk("wdf_expected", exp_wdf.size() > 0, 1);
                    if (exp_wdf.size() > 0)
                        chk("wdf_data", app_wdf_data, exp_wdf.pop_front());
                end
                if (app_en && app_rdy) begin
                    cmd_log.push_back('{app_addr, app_cmd});
                    chk("cmd_expected", exp_cmd.size() > 0, 1);
                    if (exp_cmd.size() > 0) begin
                        c = exp_cmd.pop_front();
                        chk("cmd_addr_op", {app_addr, app_cmd}, {c.a, c.c});
                    end
                    k = int'(app_addr[26:4]);
                    if (app_cmd == CMD_WR) begin
                        chk("wr_data_before_cmd", wdf_q.size() > 0, 1);
                        if (wdf_q.size() > 0) mig_mem[k] = wdf_q.pop_front();
                    end else begin
                        r.due = cyc + rd_lat;
                        r.d = mig_mem.exists(k) ? mig_mem[k] : '0;
                        rdq.push_back(r);
                    end
                end
                if (ram_rdy) begin
                    chk("ram_rdy_expected", req_q.size() > 0, 1);
                    if (req_q.size() > 0) begin
                        q = req_q.pop_front();
                        if (!q.w) exp_blk = q.blk;
                    end
                end
            end
            en_stall = rst && app_en && !app_rdy;
            wd_stall = rst && app_wdf_wren && !app_wdf_rdy;
            prev_c = '{app_addr, app_cmd};
            prev_d = app_wdf_data;
            chk("block_out", block_out, exp_blk);
            if (!rst) begin
                exp_cmd.delete();
                exp_wdf.delete();
                req_q.delete();
                wdf_q.delete();
                exp_blk = '0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int           n;
        logic [255:0] pre, d8, d;
        logic         busy;
        logic [29:0]  a;
        logic         w;
        rst = 1'b0;
        ram_en = 1'b0;
        ram_write = 1'b0;
        ram_addr = '0;
        data_to_ram = '0;
        init_calib_complete = 1'b0;
        repeat (3) @(negedge ui_clk);
        chk("rst_ram_rdy", ram_rdy, 0);
        chk("rst_app_en", app_en, 0);
        chk("rst_wren", app_wdf_wren, 0);
        chk("rst_block_out", block_out, 0);
        chk("rst_app_addr", app_addr, 0);
        chk("rst_app_cmd", app_cmd, 0);
        rst = 1'b1;

        // Calibration gate, then the literal write of {B, A} to block 5.
        @(negedge ui_clk);
        start_req(1'b1, 30'd5, {128'hB, 128'hA});
        busy = 1'b0;
        repeat (100) begin
            @(negedge ui_clk);
            if (app_en || app_wdf_wren || ram_rdy) busy = 1'b1;
        end
        chk("calib_gate_idle", busy, 0);
        cmd_log.delete();
        wdf_log.delete();
        init_calib_complete = 1'b1;
        wait_rdy(n, pre);
        chk("wr_latency_cycles", n + 1, 6);
        ram_en = 1'b0;
        @(negedge ui_clk);
        chk("ram_rdy_width", ram_rdy, 0);
        chk("wr_beats_n", wdf_log.size(), 2);
        chk("wr_beat0", wdf_log[0], 128'hA);
        chk("wr_beat1", wdf_log[1], 128'hB);
        chk("wr_cmds_n", cmd_log.size(), 2);
        chk("wr_addr0", cmd_log[0].a, 27'h0A0);
        chk("wr_addr1", cmd_log[1].a, 27'h0B0);
        chk("wr_cmd_ops", {cmd_log[0].c, cmd_log[1].c}, 6'b000_000);

        // Read with 20-cycle MIG latency from a preloaded DDR model.
        mig_mem[10] = 128'h11;
        mig_mem[11] = 128'h22;
        ref_mem[5] = {128'h22, 128'h11};
        rd_lat = 20;
        chk("blk_before_read", block_out, 0);
        start_req(1'b0, 30'd5, '0);
        wait_rdy(n, pre);
        ram_en = 1'b0;
        chk("rd_prev_held", pre, 0);
        chk("rd_block", block_out, {128'h22, 128'h11});
        @(negedge ui_clk);

        // Backpressure on both ready inputs.
        bp = 1'b1;
        rd_lat = 5;
        for (int i = 0; i < 12; i++) begin
            a = 30'(16 + $urandom_range(0, 7)) | 30'h3000_0000;
            w = (i < 6) ? 1'b1 : 1'($urandom_range(0, 1));
            d = {$urandom(), $urandom(), $urandom(), $urandom(),
                 $urandom(), $urandom(), $urandom(), $urandom()};
            start_req(w, a, d);
            wait_rdy(n, pre);
            ram_en = 1'b0;
            @(negedge ui_clk);
        end
        bp = 1'b0;
        rd_lat = 3;

        // Back-to-back: write block 8, flip to read in the ram_rdy cycle.
        cmd_log.delete();
        d8 = {128'hDEAD_BEEF_0000_0001, 128'h0123_4567_89AB_CDEF};
        start_req(1'b1, 30'd8, d8);
        wait_rdy(n, pre);
        start_req(1'b0, 30'd8, '0);
        wait_rdy(n, pre);
        ram_en = 1'b0;
        @(negedge ui_clk);
        chk("b2b_cmds_n", cmd_log.size(), 4);
        chk("b2b_ops", {cmd_log[0].c, cmd_log[1].c, cmd_log[2].c,
                        cmd_log[3].c}, 12'b000_000_001_001);
        chk("b2b_rd_block", block_out, d8);

        // Reset after the first read command is accepted.
        rd_lat = 20;
        start_req(1'b0, 30'd8, '0);
        n = 0;
        while (!(app_en && app_rdy && app_cmd == CMD_RD) && n < 50) begin
            @(negedge ui_clk);
            n++;
        end
        chk("rd_cmd_issued", app_en && app_cmd == CMD_RD, 1);
        @(negedge ui_clk);
        rst = 1'b0;
        ram_en = 1'b0;
        busy = 1'b0;
        repeat (2) begin
            @(negedge ui_clk);
            if (ram_rdy) busy = 1'b1;
        end
        rst = 1'b1;
        chk("rst_mid_blk", block_out, 0);
        repeat (30) begin
            @(negedge ui_clk);
            if (ram_rdy) busy = 1'b1;
        end
        chk("no_rdy_after_rst", busy, 0);
        chk("stale_blk_zero", block_out, 0);
        rd_lat = 3;
        start_req(1'b0, 30'd8, '0);
        wait_rdy(n, pre);
        ram_en = 1'b0;
        chk("rd_after_rst", block_out, d8);
        repeat (3) @(negedge ui_clk);

        chk("reqs_drained", req_q.size(), 0);
        foreach (ref_mem[k]) begin
            chk("mem_lo", mig_mem.exists(2 * k) ? mig_mem[2 * k] : 'x,
                ref_mem[k][127:0]);
            chk("mem_hi", mig_mem.exists(2 * k + 1) ? mig_mem[2 * k + 1] : 'x,
                ref_mem[k][255:128]);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ddr_req_responder.md
Name: ddr_req_responder

Overview:
- Responder end of the block-level RAM request protocol (ram_en / ram_write / ram_addr / data_to_ram -> ram_rdy / block_out) used by traffic generators and caches.
- Converts each 256-bit block request into two 128-bit MIG user-interface (app_*) transactions on ui_clk.
- Sits between requesters and the MIG core; all logic runs in the ui_clk domain.

Parameters:
APP_ADDR_W, 27, MIG app_addr width (byte address, 128 MB DDR2)
APP_DATA_W, 128, MIG app data width; block width is fixed at 2*APP_DATA_W = 256
RAM_ADDR_W, 30, requester block-index address width

Ports:
ui_clk  input  1  MIG user clock; all logic is on its posedge
rst  input  1  synchronous, active-low reset
ram_en  input  1  request valid, held until ram_rdy
ram_write  input  1  1 = write block, 0 = read block; stable while ram_en
ram_addr  input  RAM_ADDR_W  32-byte block index
data_to_ram  input  256  write block, stable while ram_en
ram_rdy  output  1  one-cycle completion pulse
block_out  output  256  last read block, held
init_calib_complete  input  1  MIG calibration done
app_addr  output  APP_ADDR_W  MIG byte address
app_cmd  output  3  3'b000 write, 3'b001 read
app_en  output  1  command valid
app_rdy  input  1  command accepted when app_en & app_rdy
app_wdf_data  output  APP_DATA_W  write beat
app_wdf_wren  output  1  write data valid
app_wdf_end  output  1  tied equal to app_wdf_wren (one beat per burst)
app_wdf_mask  output  APP_DATA_W/8  constant 0
app_wdf_rdy  input  1  write data accepted when wren & wdf_rdy
app_rd_data  input  APP_DATA_W  read beat
app_rd_data_valid  input  1  read beat valid

Behaviour:
- Reset (rst=0 at posedge): state IDLE, beat counters 0; ram_rdy, app_en, app_wdf_wren = 0; block_out = 0; app_addr/app_cmd = 0. Reset mid-operation abandons the request with no ram_rdy. Late MIG read beats are ignored because capture is enabled only in RD states.
- Address: app_addr = {ram_addr[APP_ADDR_W-6:0], half, 4'b0000}. half = 0 covers block bits [127:0]; half = 1 covers [255:128]. Upper ram_addr bits are dropped.
- States:
  - IDLE: if init_calib_complete & ram_en, latch addr, write flag and data; beat=0; go WR_DATA (write) or RD_CMD (read). Otherwise stay in IDLE.
  - WR_DATA: app_wdf_wren=1, data = half[beat]; on wdf_rdy go WR_CMD.
  - WR_CMD: app_en=1, cmd=000; on app_rdy: if beat=0 then beat=1 and go WR_DATA, else go DONE.
  - RD_CMD: app_en=1, cmd=001; on app_rdy: if beat=0 then beat=1 and stay, else go RD_WAIT.
  - RD_WAIT: wait until rd_cnt=2, then go DONE.
  - DONE: ram_rdy=1 for exactly one cycle; go IDLE.
- Read capture: in RD_CMD or RD_WAIT, each app_rd_data_valid writes beat rd_cnt into a staging register and increments rd_cnt. Beats may arrive while the second command is still pending. block_out updates from staging atomically in the cycle ram_rdy rises, so block_out is never half-updated.
- Request latching: the request is latched in IDLE; input changes after acceptance are ignored. The requester may present a new request in the cycle of ram_rdy. IDLE samples it on the following cycle, so one request is never accepted twice.
- Minimum latency, all ready signals high:
  - write: accept -> ram_rdy in 6 cycles (IDLE, WR_DATA, WR_CMD, WR_DATA, WR_CMD, DONE);
  - read: 3 cycles + MIG read latency.
- Writes never modify block_out. ram_en without calibration waits indefinitely.

Decomposition:
- Shared package ddr_pkg:
  - app_cmd constants CMD_WR = 3'b000, CMD_RD = 3'b001;
  - state encoding localparams;
  - BLOCK_W = 256.
- No sub-module; a single FSM plus datapath registers.

Test Plan:
- Calibration gate: init_calib_complete=0, ram_en=1 write for 100 cycles -> app_en and app_wdf_wren stay 0, no ram_rdy. Raise calib -> write proceeds.
- Write, addr 30'd5, data {128'hB, 128'hA}, MIG always ready:
  - beats 128'hA then 128'hB;
  - app_addr 27'h0A0 then 27'h0B0;
  - cmd 000 both times;
  - ram_rdy 6 cycles after acceptance, width 1.
- Read, addr 30'd5, MIG returns 128'h11 then 128'h22 with 20-cycle latency -> block_out = {128'h22, 128'h11} exactly when ram_rdy pulses; previous value held before.
- Backpressure: app_rdy and app_wdf_rdy toggled pseudo-randomly -> each beat/command issued once; app_en/wren held until accepted; final DDR model memory matches.
- Back-to-back: write to addr 8, then ram_write flips to 0 in the ram_rdy cycle while ram_en stays 1 -> exactly one write and then one read; read returns the written data.
- Reset mid-read: rst=0 after the first read command -> no ram_rdy; block_out=0. A stale beat arriving after reset leaves block_out=0, and the next read completes correctly.
